// File: rtl/acia_rx_fifo_if.sv
// Receiver-to-CPU handshake bundle for the ACIA receive FIFO.
// master = receiver/CPU side driving strobes; slave = the FIFO.
interface acia_rx_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             WR_STB;
    logic [7:0]       WR_DATA;
    logic             WR_FRAME;
    logic             WR_PARITY;
    logic             RD_STB;
    logic [7:0]       RD_DATA;
    logic             RD_FRAME;
    logic             RD_PARITY;
    logic             EMPTY;
    logic             FULL;
    logic [CNT_W-1:0] COUNT;
    logic             OVERRUN;
    logic             RTS_HOLD;

    modport master (
        output WR_STB, WR_DATA, WR_FRAME, WR_PARITY, RD_STB,
        input  RD_DATA, RD_FRAME, RD_PARITY, EMPTY, FULL, COUNT, OVERRUN, RTS_HOLD
    );

    modport slave (
        input  WR_STB, WR_DATA, WR_FRAME, WR_PARITY, RD_STB,
        output RD_DATA, RD_FRAME, RD_PARITY, EMPTY, FULL, COUNT, OVERRUN, RTS_HOLD
    );
endinterface

// File: rtl/acia_rx_fifo.sv
// ACIA receive FIFO: edge-triggered push/pop, show-ahead head register, sticky overrun.
// Define ACIA_RXFIFO_FLOWCTL_EN to enable the RTS_HOLD watermark hysteresis flag.
module acia_rx_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned HI_WATER = 12,
    parameter int unsigned LO_WATER = 4
) (
    input logic           PHI2,
    input logic           RESET,
    acia_rx_fifo_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("acia_rx_fifo: DEPTH must be a power of two and at least 4");
    end
    if (LO_WATER >= HI_WATER || HI_WATER > DEPTH) begin : g_bad_water
        $error("acia_rx_fifo: need LO_WATER < HI_WATER <= DEPTH");
    end

    logic [9:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q, wptr_nxt, rptr_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic             empty_q, full_q;
    logic             ovr_q, ovr_nxt;
    logic             wr_prev_q, rd_prev_q;
    logic [9:0]       head_q, head_nxt;
    logic [9:0]       wr_entry;
    logic             push_req, pop_req, do_push, do_pop, drop;

    always_comb begin
        wr_entry = {bus.WR_PARITY, bus.WR_FRAME, bus.WR_DATA};
        push_req = bus.WR_STB & ~wr_prev_q;
        pop_req  = bus.RD_STB & ~rd_prev_q;
        do_pop   = pop_req & ~empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        do_push  = push_req & (~full_q | do_pop);
        drop     = push_req & ~do_push;

        wptr_nxt = do_push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_nxt = do_pop  ? rptr_q + PTR_W'(1) : rptr_q;

        unique case ({do_push, do_pop})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase

        // The new head may be the slot being written on this same edge.
        head_nxt = head_q;
        if (count_nxt != '0) begin
            if (do_push && (rptr_nxt == wptr_q))
                head_nxt = wr_entry;
            else
                head_nxt = mem[rptr_nxt];
        end

        ovr_nxt = ovr_q;
        if (drop)
            ovr_nxt = 1'b1;
        else if (do_pop)
            ovr_nxt = 1'b0;
    end

    always_ff @(negedge PHI2) begin
        if (do_push)
            mem[wptr_q] <= wr_entry;
    end

    always_ff @(negedge PHI2 or negedge RESET) begin
        if (!RESET) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovr_q     <= 1'b0;
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
            head_q    <= '0;
        end else begin
            wptr_q    <= wptr_nxt;
            rptr_q    <= rptr_nxt;
            count_q   <= count_nxt;
            empty_q   <= (count_nxt == '0);
            full_q    <= (count_nxt == FULL_CNT);
            ovr_q     <= ovr_nxt;
            wr_prev_q <= bus.WR_STB;
            rd_prev_q <= bus.RD_STB;
            head_q    <= head_nxt;
        end
    end

`ifdef ACIA_RXFIFO_FLOWCTL_EN
    logic rts_q, rts_nxt;

    always_comb begin
        rts_nxt = rts_q;
        if (count_nxt >= CNT_W'(HI_WATER))
            rts_nxt = 1'b1;
        else if (count_nxt <= CNT_W'(LO_WATER))
            rts_nxt = 1'b0;
    end

    always_ff @(negedge PHI2 or negedge RESET) begin
        if (!RESET)
            rts_q <= 1'b0;
        else
            rts_q <= rts_nxt;
    end

    assign bus.RTS_HOLD = rts_q;
`else
    assign bus.RTS_HOLD = 1'b0;
`endif

    assign bus.RD_DATA   = head_q[7:0];
    assign bus.RD_FRAME  = head_q[8];
    assign bus.RD_PARITY = head_q[9];
    assign bus.EMPTY     = empty_q;
    assign bus.FULL      = full_q;
    assign bus.COUNT     = count_q;
    assign bus.OVERRUN   = ovr_q;
endmodule

// File: tb/tb_acia_rx_fifo.sv
// Self-checking bench for acia_rx_fifo: vector table plus directed multi-cycle sequences.
module tb_acia_rx_fifo;
    localparam int unsigned DEPTH = 16;
`ifdef ACIA_RXFIFO_FLOWCTL_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [7:0]  d;
        logic        fr;
        logic        par;
        logic        rd;
        int unsigned cnt;
        logic        emp;
        logic        ful;
        logic        ovr;
        logic [7:0]  q;
        logic        qfr;
        logic        qpar;
    } vec_t;

    logic        phi2 = 1'b1;
    logic        reset_n;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    vec_t        vecs[$];
    logic [7:0]  model[$];

    acia_rx_fifo_if #(.DEPTH(DEPTH)) bus();

    acia_rx_fifo #(
        .DEPTH(DEPTH),
        .HI_WATER(12),
        .LO_WATER(4)
    ) dut (
        .PHI2(phi2),
        .RESET(reset_n),
        .bus(bus.slave)
    );

    always #5 phi2 = ~phi2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [7:0] d, input logic fr,
                         input logic par, input logic rd);
        bus.WR_STB    = wr;
        bus.WR_DATA   = d;
        bus.WR_FRAME  = fr;
        bus.WR_PARITY = par;
        bus.RD_STB    = rd;
    endtask

    // Inputs change just after the rising edge; outputs are sampled just after the falling edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic fr,
                        input logic par, input logic rd);
        @(posedge phi2);
        #1;
        drive(wr, d, fr, par, rd);
        @(negedge phi2);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
        step(1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_vec(input logic wr, input logic [7:0] d, input logic fr, input logic par,
                           input logic rd, input int unsigned cnt, input logic emp, input logic ful,
                           input logic ovr, input logic [7:0] q, input logic qfr, input logic qpar);
        vec_t v;
        v.wr = wr; v.d = d; v.fr = fr; v.par = par; v.rd = rd;
        v.cnt = cnt; v.emp = emp; v.ful = ful; v.ovr = ovr;
        v.q = q; v.qfr = qfr; v.qpar = qpar;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] nxt;
        logic [7:0] expd;

        reset_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge phi2);
        #1;
        chk("rst_empty", bus.EMPTY, 1);
        chk("rst_full", bus.FULL, 0);
        chk("rst_count", bus.COUNT, 0);
        chk("rst_overrun", bus.OVERRUN, 0);
        chk("rst_rts", bus.RTS_HOLD, 0);
        chk("rst_data", bus.RD_DATA, 8'h00);
        chk("rst_frame", bus.RD_FRAME, 0);
        chk("rst_parity", bus.RD_PARITY, 0);
        @(posedge phi2);
        #1;
        reset_n = 1'b1;

        //       wr  d      fr par rd   cnt emp ful ovr q      qfr qpar
        add_vec(1, 8'h41, 0, 0, 0,   1,  0,  0,  0,  8'h41, 0,  0);
        add_vec(0, 8'h41, 0, 0, 0,   1,  0,  0,  0,  8'h41, 0,  0);
        add_vec(1, 8'h42, 0, 0, 0,   2,  0,  0,  0,  8'h41, 0,  0);
        add_vec(0, 8'h42, 0, 0, 0,   2,  0,  0,  0,  8'h41, 0,  0);
        add_vec(1, 8'h43, 0, 0, 0,   3,  0,  0,  0,  8'h41, 0,  0);
        add_vec(0, 8'h43, 0, 0, 0,   3,  0,  0,  0,  8'h41, 0,  0);
        add_vec(0, 8'h00, 0, 0, 1,   2,  0,  0,  0,  8'h42, 0,  0);
        add_vec(0, 8'h00, 0, 0, 0,   2,  0,  0,  0,  8'h42, 0,  0);
        add_vec(0, 8'h00, 0, 0, 1,   1,  0,  0,  0,  8'h43, 0,  0);
        add_vec(0, 8'h00, 0, 0, 0,   1,  0,  0,  0,  8'h43, 0,  0);
        add_vec(0, 8'h00, 0, 0, 1,   0,  1,  0,  0,  8'h43, 0,  0);
        add_vec(0, 8'h00, 0, 0, 0,   0,  1,  0,  0,  8'h43, 0,  0);
        add_vec(0, 8'h00, 0, 0, 1,   0,  1,  0,  0,  8'h43, 0,  0);
        add_vec(0, 8'h00, 0, 0, 0,   0,  1,  0,  0,  8'h43, 0,  0);
        add_vec(1, 8'h99, 0, 1, 0,   1,  0,  0,  0,  8'h99, 0,  1);
        add_vec(0, 8'h99, 0, 1, 0,   1,  0,  0,  0,  8'h99, 0,  1);
        add_vec(0, 8'h00, 0, 0, 1,   0,  1,  0,  0,  8'h99, 0,  1);
        add_vec(0, 8'h00, 0, 0, 0,   0,  1,  0,  0,  8'h99, 0,  1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wr, vecs[i].d, vecs[i].fr, vecs[i].par, vecs[i].rd);
            chk($sformatf("vec%0d_count", i), bus.COUNT, vecs[i].cnt);
            chk($sformatf("vec%0d_empty", i), bus.EMPTY, vecs[i].emp);
            chk($sformatf("vec%0d_full", i), bus.FULL, vecs[i].ful);
            chk($sformatf("vec%0d_overrun", i), bus.OVERRUN, vecs[i].ovr);
            chk($sformatf("vec%0d_data", i), bus.RD_DATA, vecs[i].q);
            chk($sformatf("vec%0d_frame", i), bus.RD_FRAME, vecs[i].qfr);
            chk($sformatf("vec%0d_parity", i), bus.RD_PARITY, vecs[i].qpar);
        end

        // Fill, overrun on the 17th push, then drain in order.
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_count", bus.COUNT, 16);
        chk("fill_full", bus.FULL, 1);
        chk("fill_overrun", bus.OVERRUN, 0);
        chk("fill_head", bus.RD_DATA, 8'h00);
        push(8'hFF);
        chk("ovr_count", bus.COUNT, 16);
        chk("ovr_full", bus.FULL, 1);
        chk("ovr_overrun", bus.OVERRUN, 1);
        chk("ovr_head", bus.RD_DATA, 8'h00);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_data", i), bus.RD_DATA, 32'(i));
            pop();
            if (i == 0) chk("drain_overrun_clr", bus.OVERRUN, 0);
        end
        chk("drain_empty", bus.EMPTY, 1);
        chk("drain_count", bus.COUNT, 0);
        chk("drain_full", bus.FULL, 0);

        // Watermark hysteresis (tied low without the flow-control build).
        for (int i = 1; i <= 12; i++) begin
            push(8'(8'h20 + i));
            if (i == 11) chk("rts_at11", bus.RTS_HOLD, 0);
            if (i == 12) chk("rts_at12", bus.RTS_HOLD, FLOW ? 1 : 0);
        end
        for (int i = 11; i >= 4; i--) begin
            pop();
            if (i == 5) chk("rts_at5", bus.RTS_HOLD, FLOW ? 1 : 0);
            if (i == 4) chk("rts_at4", bus.RTS_HOLD, 0);
        end
        chk("rts_count4", bus.COUNT, 4);
        repeat (4) pop();
        chk("rts_drain_empty", bus.EMPTY, 1);

        // Full FIFO: simultaneous push and pop.
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        chk("fullpp_count", bus.COUNT, 16);
        chk("fullpp_full", bus.FULL, 1);
        chk("fullpp_overrun", bus.OVERRUN, 0);
        chk("fullpp_head", bus.RD_DATA, 8'h11);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            expd = (i < 15) ? 8'(8'h11 + i) : 8'hAA;
            chk($sformatf("fullpp_drain%0d", i), bus.RD_DATA, expd);
            pop();
        end
        chk("fullpp_empty", bus.EMPTY, 1);

        // Empty FIFO: simultaneous push and pop.
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        chk("emptypp_count", bus.COUNT, 1);
        chk("emptypp_empty", bus.EMPTY, 0);
        chk("emptypp_head", bus.RD_DATA, 8'h55);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pop();
        chk("emptypp_drained", bus.EMPTY, 1);

        // Held strobes produce exactly one push / one pop.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
            chk($sformatf("hold_wr%0d_count", i), bus.COUNT, 1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("hold_data", bus.RD_DATA, 8'h7E);
        chk("hold_frame", bus.RD_FRAME, 1);
        chk("hold_parity", bus.RD_PARITY, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            chk($sformatf("hold_rd%0d_count", i), bus.COUNT, 0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Pointer wrap with a queue model, occupancy oscillating 2..3.
        nxt = 8'h80;
        repeat (2) begin
            push(nxt);
            model.push_back(nxt);
            nxt++;
        end
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) begin
                push(nxt);
                model.push_back(nxt);
                nxt++;
            end else begin
                chk($sformatf("wrap%0d_head", k), bus.RD_DATA, model[0]);
                void'(model.pop_front());
                pop();
            end
            chk($sformatf("wrap%0d_count", k), bus.COUNT, model.size());
        end
        chk("wrap_head_final", bus.RD_DATA, model[0]);

        // Asynchronous reset mid-stream, with WR_STB held high across release.
        @(posedge phi2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_empty", bus.EMPTY, 1);
        chk("midrst_count", bus.COUNT, 0);
        chk("midrst_data", bus.RD_DATA, 8'h00);
        chk("midrst_full", bus.FULL, 0);
        chk("midrst_overrun", bus.OVERRUN, 0);
        chk("midrst_rts", bus.RTS_HOLD, 0);
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        @(posedge phi2);
        #1;
        reset_n = 1'b1;
        @(negedge phi2);
        #1;
        chk("relhold_count", bus.COUNT, 1);
        chk("relhold_data", bus.RD_DATA, 8'h3C);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("relhold_single", bus.COUNT, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
